// File: rtl/pong_pkg.sv
// Shared types and constants for the ping-pong rally controller.
package pong_pkg;

  // One-hot rally states; the encoding is visible on the debug port.
  typedef enum logic [5:0] {
    IDLE   = 6'h01,
    MOVE_R = 6'h02,
    END_R  = 6'h04,
    MOVE_L = 6'h08,
    END_L  = 6'h10,
    DONE   = 6'h20
  } state_t;

  // Serve policies.
  localparam int SERVE_LOSER = 0;
  localparam int SERVE_ALT   = 1;

  // Player sides, also the WINNER encoding.
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/pong_rally_ctrl_if.sv
// Bundle of game-control inputs and display/timer outputs of the rally controller.
interface pong_rally_ctrl_if #(
  parameter int FIELD   = 16,
  parameter int WIN_PTS = 12
);
  localparam int PW = $clog2(FIELD);
  localparam int SW = $clog2(WIN_PTS + 1);

  logic          START;
  logic          TICK;
  logic          BTN_L;
  logic          BTN_R;
  logic [PW-1:0] POS;
  logic          DIR;
  logic [SW-1:0] SCORE_L;
  logic [SW-1:0] SCORE_R;
  logic          OVER;
  logic          WINNER;
  logic          MAXTIME;
  logic          SETTIME;
  logic [5:0]    state;

  // Driver side: button/timer logic and whatever reads the displays.
  modport master (
    output START, TICK, BTN_L, BTN_R,
    input  POS, DIR, SCORE_L, SCORE_R, OVER, WINNER, MAXTIME, SETTIME, state
  );

  // Controller side.
  modport slave (
    input  START, TICK, BTN_L, BTN_R,
    output POS, DIR, SCORE_L, SCORE_R, OVER, WINNER, MAXTIME, SETTIME, state
  );
endinterface

// File: rtl/pong_score.sv
// Per-player point counter; win flags the increment that reaches WIN_PTS.
module pong_score #(
  parameter int WIN_PTS = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           inc,
  output logic [$clog2(WIN_PTS+1)-1:0]   count,
  output logic                           win
);
  localparam int SW = $clog2(WIN_PTS + 1);

  logic [SW-1:0] r_count;
  logic [SW-1:0] w_next;

  assign w_next = r_count + SW'(1);
  assign win    = inc && (w_next == SW'(WIN_PTS));
  assign count  = r_count;

  // Count points; a new game clears the tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_next;
    end
  end
endmodule

// File: rtl/pong_rally_ctrl.sv
// Rally controller: ball position/direction, hit windows, scoring and serve policy.
module pong_rally_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD      = 16,
  parameter int WIN_PTS    = 12,
  parameter int HIT_WIN    = 1,
  parameter int SERVE_MODE = 0
) (
  input logic              CLK,
  input logic              CLRN,
  pong_rally_ctrl_if.slave bus
);
  localparam int PW = $clog2(FIELD);
  localparam int SW = $clog2(WIN_PTS + 1);

  localparam logic [PW-1:0] MID   = PW'(FIELD / 2);
  localparam logic [PW-1:0] LAST  = PW'(FIELD - 1);
  localparam logic [PW-1:0] WIN_R = PW'(FIELD - 1 - HIT_WIN);
  localparam logic [PW-1:0] WIN_L = PW'(HIT_WIN);

  state_t        r_state;
  logic [PW-1:0] r_pos;
  logic          r_dir;
  logic          r_serve;
  logic          r_over;
  logic          r_winner;

  logic          w_ret_r, w_ret_l;
  logic          w_pt_l, w_pt_r, w_point;
  logic          w_start, w_idle;
  logic          w_win_l, w_win_r;
  logic          w_scorer, w_new_dir;
  logic [SW-1:0] w_score_l, w_score_r;

  // Decode returns, points and game starts; the own-side button takes priority over TICK.
  always_comb begin
    w_ret_r = 1'b0;
    w_ret_l = 1'b0;
    w_pt_l  = 1'b0;
    w_pt_r  = 1'b0;
    w_start = 1'b0;
    case (r_state)
      MOVE_R: begin
        if (bus.BTN_R) begin
          if (r_pos >= WIN_R) w_ret_r = 1'b1;
          else                w_pt_l  = 1'b1;
        end
      end
      END_R: begin
        if (bus.BTN_R)     w_ret_r = 1'b1;
        else if (bus.TICK) w_pt_l  = 1'b1;
      end
      MOVE_L: begin
        if (bus.BTN_L) begin
          if (r_pos <= WIN_L) w_ret_l = 1'b1;
          else                w_pt_r  = 1'b1;
        end
      end
      END_L: begin
        if (bus.BTN_L)     w_ret_l = 1'b1;
        else if (bus.TICK) w_pt_r  = 1'b1;
      end
      default: w_start = bus.START;
    endcase
  end

  assign w_point   = w_pt_l | w_pt_r;
  assign w_scorer  = w_pt_r ? RIGHT : LEFT;
  // Serve toward the loser, or flip the previous serve direction.
  assign w_new_dir = (SERVE_MODE == SERVE_ALT) ? ~r_serve : ~w_scorer;
  assign w_idle    = (r_state == IDLE) || (r_state == DONE);

  pong_score #(.WIN_PTS(WIN_PTS)) u_score_l (
    .clk(CLK), .rst_n(CLRN), .clr(w_start), .inc(w_pt_l), .count(w_score_l), .win(w_win_l)
  );
  pong_score #(.WIN_PTS(WIN_PTS)) u_score_r (
    .clk(CLK), .rst_n(CLRN), .clr(w_start), .inc(w_pt_r), .count(w_score_r), .win(w_win_r)
  );

  // Rally FSM with ball position, direction, serve flop and game-over flags.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_state  <= IDLE;
      r_pos    <= MID;
      r_dir    <= 1'b1;
      r_serve  <= 1'b1;
      r_over   <= 1'b0;
      r_winner <= 1'b0;
    end else if (w_point) begin
      if (w_win_l || w_win_r) begin
        r_over   <= 1'b1;
        r_winner <= w_scorer;
        r_state  <= DONE;
      end else begin
        r_pos   <= MID;
        r_dir   <= w_new_dir;
        r_serve <= w_new_dir;
        r_state <= w_new_dir ? MOVE_R : MOVE_L;
      end
    end else if (w_ret_r) begin
      r_dir   <= 1'b0;
      r_state <= MOVE_L;
    end else if (w_ret_l) begin
      r_dir   <= 1'b1;
      r_state <= MOVE_R;
    end else begin
      case (r_state)
        MOVE_R: begin
          if (bus.TICK) begin
            if (r_pos == LAST) r_state <= END_R;
            else               r_pos   <= r_pos + PW'(1);
          end
        end
        MOVE_L: begin
          if (bus.TICK) begin
            if (r_pos == '0) r_state <= END_L;
            else             r_pos   <= r_pos - PW'(1);
          end
        end
        IDLE, DONE: begin
          if (bus.START) begin
            r_over  <= 1'b0;
            r_pos   <= MID;
            r_serve <= r_dir;
            r_state <= r_dir ? MOVE_R : MOVE_L;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.POS     = r_pos;
  assign bus.DIR     = r_dir;
  assign bus.SCORE_L = w_score_l;
  assign bus.SCORE_R = w_score_r;
  assign bus.OVER    = r_over;
  assign bus.WINNER  = r_winner;
  assign bus.state   = r_state;
  assign bus.MAXTIME = w_idle | w_point;
  assign bus.SETTIME = w_ret_r | w_ret_l;
endmodule

// File: tb/tb_pong_rally_ctrl.sv
module tb_pong_rally_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_rally_ctrl_if #(.FIELD(8), .WIN_PTS(3)) bus0 ();
  pong_rally_ctrl_if #(.FIELD(8), .WIN_PTS(3)) bus1 ();

  pong_rally_ctrl #(.FIELD(8), .WIN_PTS(3), .HIT_WIN(1), .SERVE_MODE(0)) dut0 (
    .CLK(clk), .CLRN(rst_n), .bus(bus0)
  );
  pong_rally_ctrl #(.FIELD(8), .WIN_PTS(3), .HIT_WIN(1), .SERVE_MODE(1)) dut1 (
    .CLK(clk), .CLRN(rst_n), .bus(bus1)
  );

  // Snapshot layout: st[17:12] pos[11:9] dir[8] sl[7:6] sr[5:4] ov[3] wn[2] mt[1] stt[0]
  typedef struct {
    int          cyc;
    int          d;
    string       name;
    logic [17:0] val;
    logic [17:0] mask;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [17:0] snap(int d);
    if (d == 0)
      return {bus0.state, bus0.POS, bus0.DIR, bus0.SCORE_L, bus0.SCORE_R,
              bus0.OVER, bus0.WINNER, bus0.MAXTIME, bus0.SETTIME};
    else
      return {bus1.state, bus1.POS, bus1.DIR, bus1.SCORE_L, bus1.SCORE_R,
              bus1.OVER, bus1.WINNER, bus1.MAXTIME, bus1.SETTIME};
  endfunction

  // Monitor: sample away from the active edge, pop expectations due this cycle.
  exp_t        m_e;
  logic [17:0] m_a;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc_cnt) begin
      m_e = q.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL %s dut%0d: not sampled, got=none want=%05h", m_e.name, m_e.d, m_e.val);
    end
    while (q.size() > 0 && q[0].cyc == cyc_cnt) begin
      m_e = q.pop_front();
      m_a = snap(m_e.d);
      n_checks++;
      if ((m_a & m_e.mask) !== (m_e.val & m_e.mask)) begin
        n_err++;
        $display("FAIL %s dut%0d: got=%05h want=%05h mask=%05h", m_e.name, m_e.d,
                 m_a & m_e.mask, m_e.val & m_e.mask, m_e.mask);
      end else begin
        $display("ok   %s dut%0d: %05h", m_e.name, m_e.d, m_a & m_e.mask);
      end
    end
  end

  task automatic set_in(int d, bit s, bit t, bit bl, bit br);
    bus0.START = 1'b0; bus0.TICK = 1'b0; bus0.BTN_L = 1'b0; bus0.BTN_R = 1'b0;
    bus1.START = 1'b0; bus1.TICK = 1'b0; bus1.BTN_L = 1'b0; bus1.BTN_R = 1'b0;
    if (d == 0) begin
      bus0.START = s; bus0.TICK = t; bus0.BTN_L = bl; bus0.BTN_R = br;
    end else begin
      bus1.START = s; bus1.TICK = t; bus1.BTN_L = bl; bus1.BTN_R = br;
    end
  endtask

  task automatic push(string name, int d, logic [17:0] val, logic [17:0] mask);
    exp_t e;
    e.cyc = cyc_cnt; e.d = d; e.name = name; e.val = val; e.mask = mask;
    q.push_back(e);
  endtask

  // One-cycle input pulse; checks the combinational timer outputs during it.
  task automatic pulse(int d, bit s, bit t, bit bl, bit br, bit mt, bit stt, string name);
    @(posedge clk); #1;
    set_in(d, s, t, bl, br);
    push(name, d, {16'h0, mt, stt}, 18'h00003);
  endtask

  // Quiet cycle; checks every output (SETTIME must be low).
  task automatic idle(int d, string name, logic [5:0] st, logic [2:0] pos, logic dir,
                      logic [1:0] sl, logic [1:0] sr, logic ov, logic wn, logic mt);
    @(posedge clk); #1;
    set_in(d, 0, 0, 0, 0);
    push(name, d, {st, pos, dir, sl, sr, ov, wn, mt, 1'b0}, 18'h3FFFF);
  endtask

  // Reset asserted mid-cycle: outputs must take reset values before the next edge.
  task automatic do_reset(string name);
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    push(name, 0, {IDLE, 3'd4, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}, 18'h3FFFF);
    push(name, 1, {IDLE, 3'd4, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}, 18'h3FFFF);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle ignores TICK and buttons
    for (int i = 0; i < 10; i++) pulse(0, 0, 1, i == 3, i == 5, 1, 0, "idle_tick");
    idle(0, "idle_hold", IDLE, 3'd4, 1, 2'd0, 2'd0, 0, 0, 1);

    // 2: serve right, step to the end cell, return
    pulse(0, 1, 0, 0, 0, 1, 0, "start_idle");
    idle(0, "started", MOVE_R, 3'd4, 1, 2'd0, 2'd0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    idle(0, "pos5", MOVE_R, 3'd5, 1, 2'd0, 2'd0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    idle(0, "pos6", MOVE_R, 3'd6, 1, 2'd0, 2'd0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    idle(0, "pos7", MOVE_R, 3'd7, 1, 2'd0, 2'd0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 0, 1, "return_r");
    idle(0, "after_ret", MOVE_L, 3'd7, 0, 2'd0, 2'd0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    idle(0, "pos6_left", MOVE_L, 3'd6, 0, 2'd0, 2'd0, 0, 0, 0);

    // 3: early press is a fault; serve policy in both modes
    do_reset("rst_a");
    idle(0, "rst_a_rel", IDLE, 3'd4, 1, 2'd0, 2'd0, 0, 0, 1);
    pulse(0, 1, 0, 0, 0, 1, 0, "start_idle");
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    idle(0, "pos5", MOVE_R, 3'd5, 1, 2'd0, 2'd0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 1, 0, "fault_r");
    idle(0, "pt_l_mode0", MOVE_R, 3'd4, 1, 2'd1, 2'd0, 0, 0, 0);
    pulse(1, 1, 0, 0, 0, 1, 0, "start_idle");
    pulse(1, 0, 1, 0, 0, 0, 0, "tick");
    pulse(1, 0, 0, 0, 1, 1, 0, "fault_r");
    idle(1, "pt_l_mode1", MOVE_L, 3'd4, 0, 2'd1, 2'd0, 0, 0, 0);

    // 4: simultaneous TICK+button, left return, miss at END_R
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 1, 0, 1, 0, 1, "tick_and_btn");
    idle(0, "same_cycle", MOVE_L, 3'd6, 0, 2'd1, 2'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 0, 1, 0, 0, 1, "return_l");
    idle(0, "ret_l", MOVE_R, 3'd1, 1, 2'd1, 2'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 1, 0, 0, 0, 0, "tick_to_end");
    idle(0, "end_r", END_R, 3'd7, 1, 2'd1, 2'd0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 1, 0, "miss_r");
    idle(0, "pt_miss", MOVE_R, 3'd4, 1, 2'd2, 2'd0, 0, 0, 0);

    // 5: winning point, frozen DONE, restart
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 0, 0, 1, 1, 0, "win_pt");
    idle(0, "game_over", DONE, 3'd5, 1, 2'd3, 2'd0, 1, 0, 1);
    pulse(0, 0, 1, 0, 0, 1, 0, "done_tick");
    pulse(0, 0, 0, 1, 0, 1, 0, "done_btn_l");
    pulse(0, 0, 0, 0, 1, 1, 0, "done_btn_r");
    idle(0, "done_frozen", DONE, 3'd5, 1, 2'd3, 2'd0, 1, 0, 1);
    pulse(0, 1, 0, 0, 0, 1, 0, "start_done");
    idle(0, "restart", MOVE_R, 3'd4, 1, 2'd0, 2'd0, 0, 0, 0);

    // 6: right player to 2 points, ball at 1, then reset mid-rally
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    pulse(0, 0, 0, 0, 1, 0, 1, "return_r");
    pulse(0, 0, 0, 1, 0, 1, 0, "fault_l");
    idle(0, "pt_r1", MOVE_L, 3'd4, 0, 2'd0, 2'd1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 1, 0, "fault_l");
    for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0, 0, 0, 0, "tick");
    idle(0, "pre_reset", MOVE_L, 3'd1, 0, 2'd0, 2'd2, 0, 0, 0);
    do_reset("rst_mid");
    idle(0, "post_reset", IDLE, 3'd4, 1, 2'd0, 2'd0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;

    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained: got=%0d want=0", q.size());
    end else begin
      $display("ok   queue_drained: 0");
    end

    n_checks++;
    if (bus0.state !== IDLE) begin
      n_err++;
      $display("FAIL final_state dut0: got=%02h want=%02h", bus0.state, IDLE);
    end else begin
      $display("ok   final_state dut0: %02h", bus0.state);
    end

    n_checks++;
    if (bus0.POS !== 3'd4) begin
      n_err++;
      $display("FAIL final_pos dut0: got=%0d want=4", bus0.POS);
    end else begin
      $display("ok   final_pos dut0: %0d", bus0.POS);
    end

    n_checks++;
    if (bus1.DIR !== 1'b1) begin
      n_err++;
      $display("FAIL final_dir dut1: got=%0b want=1", bus1.DIR);
    end else begin
      $display("ok   final_dir dut1: %0b", bus1.DIR);
    end

    n_checks++;
    if (bus0.MAXTIME !== 1'b1) begin
      n_err++;
      $display("FAIL final_maxtime dut0: got=%0b want=1", bus0.MAXTIME);
    end else begin
      $display("ok   final_maxtime dut0: %0b", bus0.MAXTIME);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
